// File: rtl/univ_cnt_pkg.sv
// Shared types and operation decode for the universal counter/shift register.
package univ_cnt_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_SHR,
    OP_SHL
  } op_e;

  // Inc and dec together cancel and also mask any lower shift request.
  function automatic op_e decode_op(
    input logic load,
    input logic inc,
    input logic dec,
    input logic shr,
    input logic shl
  );
    op_e op;
    priority case (1'b1)
      load:         op = OP_LOAD;
      (inc && dec): op = OP_HOLD;
      inc:          op = OP_INC;
      dec:          op = OP_DEC;
      shr:          op = OP_SHR;
      shl:          op = OP_SHL;
      default:      op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/univ_cnt_arith.sv
// Modular add/sub of Value +/- Step over 0..MAX_COUNT, with optional saturation.
module univ_cnt_arith
  import univ_cnt_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int STEP_W    = 4
) (
  input  logic [WIDTH-1:0]  Value,
  input  logic [STEP_W-1:0] Step,
  input  logic              Saturate,
  input  logic              IsDec,
  output logic [WIDTH-1:0]  NextValue,
  output logic              Flag
);

  localparam logic [WIDTH:0]   MaxExt = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MaxV   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   One    = (WIDTH+1)'(1);

  logic [WIDTH:0] val;
  logic [WIDTH:0] stp;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sumWrap;
  logic [WIDTH:0] sub;
  logic [WIDTH:0] subWrap;

  assign val     = {1'b0, Value};
  assign stp     = (WIDTH+1)'(Step);
  assign sum     = val + stp;
  assign sumWrap = sum - MaxExt - One;
  assign sub     = val - stp;
  assign subWrap = val + MaxExt + One - stp;

  always_comb begin
    NextValue = Value;
    Flag      = 1'b0;
    if (stp == '0) begin
      NextValue = Value;
    end else if (!IsDec) begin
      if (val > MaxExt) begin
        NextValue = '0;
        Flag      = 1'b1;
      end else if (sum > MaxExt) begin
        NextValue = Saturate ? MaxV : WIDTH'(sumWrap);
        Flag      = 1'b1;
      end else begin
        NextValue = WIDTH'(sum);
      end
    end else begin
      // Out-of-range values re-enter at the top without a borrow.
      if (val > MaxExt) begin
        NextValue = MaxV;
      end else if (val >= stp) begin
        NextValue = WIDTH'(sub);
      end else begin
        NextValue = Saturate ? '0 : WIDTH'(subWrap);
        Flag      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/univ_counter_reg.sv
// Loadable up/down counter with serial shift; optional UNIV_CNT_LOAD_CLAMP_EN
// clamps loads above MAX_COUNT and flags them with Carry.
module univ_counter_reg
  import univ_cnt_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int STEP_W    = 4
) (
  input  logic              Clock,
  input  logic              DoReset,
  input  logic [WIDTH-1:0]  CounterInData,
  input  logic              CounterInMSB,
  input  logic              CounterInLSB,
  input  logic [STEP_W-1:0] Step,
  input  logic              Saturate,
  input  logic              DoLoad,
  input  logic              DoIncrement,
  input  logic              DoDecrement,
  input  logic              DoShiftL2R,
  input  logic              DoShiftR2L,
  output logic [WIDTH-1:0]  CounterOut,
  output logic              Carry,
  output logic              Borrow,
  output logic              ShiftOut,
  output logic              AtMax,
  output logic              AtZero
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_COUNT);

  op_e              op;
  logic [WIDTH-1:0] arithNext;
  logic             arithFlag;

  assign op = decode_op(DoLoad, DoIncrement, DoDecrement,
                        DoShiftL2R, DoShiftR2L);

  univ_cnt_arith #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .STEP_W    (STEP_W)
  ) uArith (
    .Value     (CounterOut),
    .Step      (Step),
    .Saturate  (Saturate),
    .IsDec     (op == OP_DEC),
    .NextValue (arithNext),
    .Flag      (arithFlag)
  );

  always_ff @(posedge Clock) begin
    if (DoReset) begin
      CounterOut <= '0;
      Carry      <= 1'b0;
      Borrow     <= 1'b0;
      ShiftOut   <= 1'b0;
    end else begin
      Carry  <= 1'b0;
      Borrow <= 1'b0;
      unique case (op)
        OP_LOAD: begin
`ifdef UNIV_CNT_LOAD_CLAMP_EN
          if (CounterInData > MaxV) begin
            CounterOut <= MaxV;
            Carry      <= 1'b1;
          end else begin
            CounterOut <= CounterInData;
          end
`else
          CounterOut <= CounterInData;
`endif
        end
        OP_INC: begin
          CounterOut <= arithNext;
          Carry      <= arithFlag;
        end
        OP_DEC: begin
          CounterOut <= arithNext;
          Borrow     <= arithFlag;
        end
        OP_SHR: begin
          CounterOut <= {CounterInMSB, CounterOut[WIDTH-1:1]};
          ShiftOut   <= CounterOut[0];
        end
        OP_SHL: begin
          CounterOut <= {CounterOut[WIDTH-2:0], CounterInLSB};
          ShiftOut   <= CounterOut[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  assign AtMax  = (CounterOut == MaxV);
  assign AtZero = (CounterOut == '0);

endmodule

// File: tb/tb_univ_counter_reg.sv
// Self-checking bench for univ_counter_reg: directed table plus random run
// against an arithmetic reference model.
module tb_univ_counter_reg;

  localparam int W  = 8;
  localparam int M  = 9;
  localparam int SW = 4;
`ifdef UNIV_CNT_LOAD_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          DoReset;
  logic [W-1:0]  CounterInData;
  logic          CounterInMSB;
  logic          CounterInLSB;
  logic [SW-1:0] Step;
  logic          Saturate;
  logic          DoLoad;
  logic          DoIncrement;
  logic          DoDecrement;
  logic          DoShiftL2R;
  logic          DoShiftR2L;
  logic [W-1:0]  CounterOut;
  logic          Carry;
  logic          Borrow;
  logic          ShiftOut;
  logic          AtMax;
  logic          AtZero;

  always #5 Clock = ~Clock;

  univ_counter_reg #(
    .WIDTH     (W),
    .MAX_COUNT (M),
    .STEP_W    (SW)
  ) dut (
    .Clock         (Clock),
    .DoReset       (DoReset),
    .CounterInData (CounterInData),
    .CounterInMSB  (CounterInMSB),
    .CounterInLSB  (CounterInLSB),
    .Step          (Step),
    .Saturate      (Saturate),
    .DoLoad        (DoLoad),
    .DoIncrement   (DoIncrement),
    .DoDecrement   (DoDecrement),
    .DoShiftL2R    (DoShiftL2R),
    .DoShiftR2L    (DoShiftR2L),
    .CounterOut    (CounterOut),
    .Carry         (Carry),
    .Borrow        (Borrow),
    .ShiftOut      (ShiftOut),
    .AtMax         (AtMax),
    .AtZero        (AtZero)
  );

  typedef struct {
    string op;
    int    data;
    int    step;
    bit    sat;
    bit    sin;
    int    eOut;
    bit    eC;
    bit    eB;
    bit    eS;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model state
  int mv, mc, mb, ms;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(string tag, int eo, bit ec, bit eb, bit es);
    check({tag, ".out"},    32'(CounterOut), 32'(eo));
    check({tag, ".carry"},  32'(Carry),      32'(ec));
    check({tag, ".borrow"}, 32'(Borrow),     32'(eb));
    check({tag, ".sout"},   32'(ShiftOut),   32'(es));
    check({tag, ".atmax"},  32'(AtMax),      32'(eo == M));
    check({tag, ".atzero"}, 32'(AtZero),     32'(eo == 0));
  endtask

  task automatic drive(string op, int data, int step, bit sat, bit sin);
    DoReset       = 1'b0;
    DoLoad        = 1'b0;
    DoIncrement   = 1'b0;
    DoDecrement   = 1'b0;
    DoShiftL2R    = 1'b0;
    DoShiftR2L    = 1'b0;
    CounterInData = W'(data);
    Step          = SW'(step);
    Saturate      = sat;
    CounterInMSB  = sin;
    CounterInLSB  = sin;
    case (op)
      "RSTALL": begin
        DoReset = 1; DoLoad = 1; DoIncrement = 1; DoDecrement = 1;
        DoShiftL2R = 1; DoShiftR2L = 1;
      end
      "RST":    begin DoReset = 1; DoIncrement = 1; end
      "LD":     DoLoad = 1;
      "INC":    DoIncrement = 1;
      "DEC":    DoDecrement = 1;
      "L2R":    DoShiftL2R = 1;
      "R2L":    DoShiftR2L = 1;
      "LDINC":  begin DoLoad = 1; DoIncrement = 1; end
      "INCDEC": begin DoIncrement = 1; DoDecrement = 1; DoShiftL2R = 1; end
      default:  ;
    endcase
  endtask

  task automatic modelStep(bit rst, bit ld, bit inc, bit dec, bit l2r,
                           bit r2l, int data, int step, bit sat,
                           bit msb, bit lsb);
    if (rst) begin
      mv = 0; mc = 0; mb = 0; ms = 0;
    end else begin
      mc = 0; mb = 0;
      if (ld) begin
        if (CLAMP && data > M) begin mv = M; mc = 1; end
        else mv = data;
      end else if (inc && dec) begin
      end else if (inc) begin
        if (mv > M) begin mv = 0; mc = 1; end
        else if (mv + step > M) begin
          mc = 1;
          mv = sat ? M : (mv + step) % (M + 1);
        end else mv = mv + step;
      end else if (dec) begin
        if (mv > M) mv = M;
        else if (mv >= step) mv = mv - step;
        else begin
          mb = 1;
          mv = sat ? 0 : mv + M + 1 - step;
        end
      end else if (l2r) begin
        ms = mv % 2;
        mv = mv / 2 + (msb ? 128 : 0);
      end else if (r2l) begin
        ms = mv / 128;
        mv = (mv * 2) % 256 + (lsb ? 1 : 0);
      end
    end
  endtask

  initial begin
    drive("NONE", 0, 0, 0, 0);

    //            op        data  stp sat sin  out             c      b  s
    vecs.push_back('{"RSTALL", 0,    0, 0, 1,   0,              0,     0, 0});
    vecs.push_back('{"LD",     7,    0, 0, 0,   7,              0,     0, 0});
    vecs.push_back('{"INC",    0,    2, 0, 0,   9,              0,     0, 0});
    vecs.push_back('{"INC",    0,    2, 0, 0,   1,              1,     0, 0});
    vecs.push_back('{"NONE",   0,    2, 0, 0,   1,              0,     0, 0});
    vecs.push_back('{"LD",     1,    0, 0, 0,   1,              0,     0, 0});
    vecs.push_back('{"DEC",    0,    3, 0, 0,   8,              0,     1, 0});
    vecs.push_back('{"LD",     1,    0, 0, 0,   1,              0,     0, 0});
    vecs.push_back('{"DEC",    0,    3, 1, 0,   0,              0,     1, 0});
    vecs.push_back('{"LD",     'h81, 0, 0, 0,   'h81,           0,     0, 0});
    vecs.push_back('{"L2R",    0,    0, 0, 1,   'hC0,           0,     0, 1});
    vecs.push_back('{"L2R",    0,    0, 0, 1,   'hE0,           0,     0, 0});
    vecs.push_back('{"L2R",    0,    0, 0, 1,   'hF0,           0,     0, 0});
    vecs.push_back('{"L2R",    0,    0, 0, 1,   'hF8,           0,     0, 0});
    vecs.push_back('{"LD",     'h81, 0, 0, 0,   'h81,           0,     0, 0});
    vecs.push_back('{"R2L",    0,    0, 0, 0,   'h02,           0,     0, 1});
    vecs.push_back('{"INC",    0,    1, 0, 0,   3,              0,     0, 1});
    vecs.push_back('{"LDINC",  5,    1, 0, 0,   5,              0,     0, 1});
    vecs.push_back('{"INCDEC", 0,    1, 0, 1,   5,              0,     0, 1});
    vecs.push_back('{"INC",    0,    0, 0, 0,   5,              0,     0, 1});
    vecs.push_back('{"DEC",    0,    0, 0, 0,   5,              0,     0, 1});
    vecs.push_back('{"LD",     200,  0, 0, 0,   CLAMP ? 9 : 200, CLAMP, 0, 1});
    vecs.push_back('{"INC",    0,    1, 0, 0,   0,              1,     0, 1});
    vecs.push_back('{"LD",     200,  0, 0, 0,   CLAMP ? 9 : 200, CLAMP, 0, 1});
    vecs.push_back('{"DEC",    0,    3, 0, 0,   CLAMP ? 6 : 9,  0,     0, 1});
    vecs.push_back('{"LD",     8,    0, 0, 0,   8,              0,     0, 1});
    vecs.push_back('{"INC",    0,    5, 1, 0,   9,              1,     0, 1});
    vecs.push_back('{"RST",    0,    1, 0, 0,   0,              0,     0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].data, vecs[i].step, vecs[i].sat, vecs[i].sin);
      @(posedge Clock);
      #1;
      checkAll($sformatf("vec%0d_%s", i, vecs[i].op),
               vecs[i].eOut, vecs[i].eC, vecs[i].eB, vecs[i].eS);
    end

    mv = 0; mc = 0; mb = 0; ms = 0;
    for (int n = 0; n < 400; n++) begin
      DoReset       = ($urandom_range(0, 39) == 0);
      DoLoad        = ($urandom_range(0, 7) == 0);
      DoIncrement   = ($urandom_range(0, 2) == 0);
      DoDecrement   = ($urandom_range(0, 2) == 0);
      DoShiftL2R    = ($urandom_range(0, 3) == 0);
      DoShiftR2L    = ($urandom_range(0, 3) == 0);
      CounterInData = W'($urandom_range(0, 255));
      Step          = SW'($urandom_range(1, M));
      Saturate      = 1'($urandom_range(0, 1));
      CounterInMSB  = 1'($urandom_range(0, 1));
      CounterInLSB  = 1'($urandom_range(0, 1));
      modelStep(DoReset, DoLoad, DoIncrement, DoDecrement, DoShiftL2R,
                DoShiftR2L, int'(CounterInData), int'(Step), Saturate,
                CounterInMSB, CounterInLSB);
      @(posedge Clock);
      #1;
      checkAll($sformatf("rnd%0d", n), mv, mc[0], mb[0], ms[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
